// File: rtl/bloom_wr_arbiter_if.sv
// Requester and Avalon-MM write-master signals of the Bloom-filter write arbiter.
// The master modport is the arbiter; the slave modport is the requesters plus the memory.
interface bloom_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int AMM_ADDR_W = 5,
  parameter int AMM_DATA_W = 1
);
  logic [NUM_REQ-1:0]            req_valid_i;
  logic [NUM_REQ*AMM_ADDR_W-1:0] req_addr_i;
  logic [NUM_REQ-1:0]            req_ready_o;
  logic [AMM_ADDR_W-1:0]         amm_master_address_o;
  logic                          amm_master_write_o;
  logic [AMM_DATA_W-1:0]         amm_master_writedata_o;
  logic                          amm_master_waitrequest_i;

  modport master (
    input  req_valid_i, req_addr_i, amm_master_waitrequest_i,
    output req_ready_o, amm_master_address_o, amm_master_write_o, amm_master_writedata_o
  );

  modport slave (
    output req_valid_i, req_addr_i, amm_master_waitrequest_i,
    input  req_ready_o, amm_master_address_o, amm_master_write_o, amm_master_writedata_o
  );
endinterface

// File: rtl/bloom_wr_arbiter.sv
// Sole owner of the Bloom-filter memory write port: round-robin insert arbitration
// plus a full-memory clear sweep, both honouring slave waitrequest.
//   state    | meaning
//   ST_RUN   | granting inserts round-robin
//   ST_DRAIN | clear requested, waiting for the stalled write to be accepted
//   ST_CLEAR | writing CLEAR_DATA to every address 0..2**AMM_ADDR_W-1
module bloom_wr_arbiter #(
  parameter int                    NUM_REQ        = 4,
  parameter int                    AMM_ADDR_W     = 5,
  parameter int                    AMM_DATA_W     = 1,
  parameter logic [AMM_DATA_W-1:0] SET_DATA       = '1,
  parameter logic [AMM_DATA_W-1:0] CLEAR_DATA     = '0,
  parameter bit                    CLEAR_ON_RESET = 1'b1
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  bloom_wr_arbiter_if.master  bus,
  input  logic                clear_stb_i,
  output logic                clear_busy_o,
  output logic                clear_done_o
);

  localparam int RR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [AMM_ADDR_W-1:0] ADDR_LAST = '1;

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_CLEAR} state_t;

  state_t                state_q;
  logic [AMM_ADDR_W-1:0] addr_q;
  logic                  write_q;
  logic [AMM_DATA_W-1:0] wdata_q;
  logic                  busy_q;
  logic                  done_q;
  logic [RR_W-1:0]       rr_q;

  logic                  slot_free;
  logic                  gnt_found;
  logic [RR_W-1:0]       gnt_idx;
  logic                  grant_ok;
  logic [AMM_ADDR_W-1:0] gnt_addr;

  assign slot_free = !write_q || !bus.amm_master_waitrequest_i;

  // First valid requester strictly after the last winner, wrapping cyclically.
  always_comb begin
    int k;
    logic [RR_W-1:0] idx;
    k         = 0;
    idx       = '0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      k = int'(rr_q) + i;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      idx = RR_W'(k);
      if (!gnt_found && bus.req_valid_i[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = idx;
      end
    end
  end

  assign gnt_addr = bus.req_addr_i[int'(gnt_idx)*AMM_ADDR_W +: AMM_ADDR_W];
  // A clear strobe pre-empts any grant in the same cycle.
  assign grant_ok = rst_n_i && (state_q == ST_RUN) && !clear_stb_i && slot_free && gnt_found;

  assign bus.req_ready_o            = grant_ok ? (NUM_REQ'(1) << gnt_idx) : '0;
  assign bus.amm_master_address_o   = addr_q;
  assign bus.amm_master_write_o     = write_q;
  assign bus.amm_master_writedata_o = wdata_q;
  assign clear_busy_o               = busy_q;
  assign clear_done_o               = done_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      busy_q  <= CLEAR_ON_RESET;
      done_q  <= 1'b0;
      rr_q    <= RR_W'(NUM_REQ - 1);
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_RUN: begin
          if (clear_stb_i) begin
            busy_q <= 1'b1;
            if (slot_free) begin
              state_q <= ST_CLEAR;
              addr_q  <= '0;
              write_q <= 1'b1;
              wdata_q <= CLEAR_DATA;
            end else begin
              state_q <= ST_DRAIN;
            end
          end else if (grant_ok) begin
            addr_q  <= gnt_addr;
            write_q <= 1'b1;
            wdata_q <= SET_DATA;
            rr_q    <= gnt_idx;
          end else if (slot_free) begin
            write_q <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (!bus.amm_master_waitrequest_i) begin
            state_q <= ST_CLEAR;
            addr_q  <= '0;
            write_q <= 1'b1;
            wdata_q <= CLEAR_DATA;
          end
        end
        ST_CLEAR: begin
          // write_q is low only on the first cycle after reset release.
          if (!write_q) begin
            write_q <= 1'b1;
            wdata_q <= CLEAR_DATA;
          end else if (!bus.amm_master_waitrequest_i) begin
            if (addr_q == ADDR_LAST) begin
              write_q <= 1'b0;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= ST_RUN;
            end else begin
              addr_q <= addr_q + 1'b1;
            end
          end
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

endmodule
